// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants used by fetch and decode.
package rv32_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [4:0] OP     = 5'b01100;
    localparam logic [4:0] OP_IMM = 5'b00100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, ins} entries; flush wins over push.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Upstream credit accounting must make these unreachable.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, credit-limited imem requests, wrong-path drop on redirect.
//   state | meaning
//   BOOT  | single idle cycle after reset release
//   FETCH | issuing requests, pushing responses into the buffer
//   DRAIN | no requests; discarding `drop` wrong-path responses
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] out_after_rsp;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      target_pc;
    logic             accept, push, pop;
    logic             fifo_full, fifo_empty;
    fetch_entry_t     push_entry, head;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        rsp_pc_d       = rsp_pc_q;
        drop_d         = drop_q;
        target_pc      = word_align(redirect_pc);
        out_after_rsp  = outstanding_q - CNT_W'(imem_rsp_valid);

        // Sum of in-flight and buffered words never exceeds the buffer, so no rsp backpressure.
        imem_req_valid = (state_q == FETCH) && !redirect_valid &&
                         (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_C);
        imem_req_addr  = pc_q;
        accept         = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
        outstanding_d  = out_after_rsp + CNT_W'(accept);
        push_entry     = '{pc: rsp_pc_q, ins: imem_rsp_data};

        if (redirect_valid) begin
            pc_d     = target_pc;
            rsp_pc_d = target_pc;
            drop_d   = out_after_rsp;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end

        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = (redirect_valid && (out_after_rsp != '0)) ? DRAIN : FETCH;
            DRAIN:   state_d = (drop_d == '0) ? FETCH : DRAIN;
            default: state_d = BOOT;
        endcase

        ins_valid = !fifo_empty;
        pop       = ins_valid && ins_ready;
        ins       = ins_valid ? head.ins : NOP_INSN;
        ins_pc    = ins_valid ? head.pc  : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_rsp_fits: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full && !redirect_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based in-order instruction memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic        mem_hold;
    logic [31:0] mem_q   [$];
    logic [31:0] acc_log [$];
    logic [31:0] del_pc  [$];
    logic [31:0] del_ins [$];

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] log_at(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory model: responds one cycle after accept, in order; log accepts and pops on the edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (imem_rsp_valid && mem_q.size() > 0) mem_q.delete(0);
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back(imem_req_addr);
                acc_log.push_back(imem_req_addr);
            end
            if (ins_valid && ins_ready) begin
                del_pc.push_back(ins_pc);
                del_ins.push_back(ins);
            end
            #1;
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0]);
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        acc_log.delete();
        del_pc.delete();
        del_ins.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_hold       = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_deliv(input int n);
        int b;
        b = 0;
        while (del_pc.size() < n && b < 100) begin
            @(negedge clk);
            b++;
        end
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        do_reset();
        rst = 1'b0;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        n_tests++;
        if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr got %h want 00000000", imem_req_addr); end
        n_tests++;
        if (ins !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_ins got %h want 00000013", ins); end
        n_tests++;
        if (ins_pc !== 32'h0 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ins_pc_valid got %h/%b want 0/0", ins_pc, ins_valid); end
    endtask

    task automatic test_basic_stream();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        do_reset();
        n_tests++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_idle req_valid got %b want 0", imem_req_valid); end
        @(negedge clk);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || acc_log.size() != 0) begin
            n_fail++; $display("FAIL first_req got v=%b a=%h n=%0d want v=1 a=0 n=0", imem_req_valid, imem_req_addr, acc_log.size());
        end
        @(negedge clk);
        n_tests++;
        if (acc_log.size() != 1 || ins_valid !== 1'b0) begin
            n_fail++; $display("FAIL accept_cycle2 got n=%0d iv=%b want n=1 iv=0", acc_log.size(), ins_valid);
        end
        @(negedge clk);
        n_tests++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h0) begin
            n_fail++; $display("FAIL first_ins_latency got iv=%b pc=%h want iv=1 pc=0", ins_valid, ins_pc);
        end
        wait_deliv(3);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (log_at(acc_log, i) !== 32'(4 * i) || log_at(del_pc, i) !== 32'(4 * i) ||
                log_at(del_ins, i) !== mem_word(32'(4 * i))) begin
                n_fail++; $display("FAIL stream_%0d got addr=%h pc=%h ins=%h want %h/%h/%h", i,
                    log_at(acc_log, i), log_at(del_pc, i), log_at(del_ins, i), 32'(4 * i), 32'(4 * i), mem_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        n_tests++;
        if (acc_log.size() != 2 || imem_req_valid !== 1'b0 || ins_valid !== 1'b1 || ins_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_full got n=%0d rv=%b iv=%b pc=%h want 2/0/1/0", acc_log.size(), imem_req_valid, ins_valid, ins_pc);
        end
        for (int k = 0; k < 2; k++) begin
            ins_ready = 1'b1;
            @(negedge clk);
            ins_ready = 1'b0;
            repeat (4) @(negedge clk);
            n_tests++;
            if (acc_log.size() != 3 + k || log_at(acc_log, 2 + k) !== 32'(8 + 4 * k) ||
                log_at(del_pc, k) !== 32'(4 * k) || imem_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_pop_%0d got n=%0d addr=%h pc=%h rv=%b want n=%0d addr=%h pc=%h rv=0", k,
                    acc_log.size(), log_at(acc_log, 2 + k), log_at(del_pc, k), imem_req_valid, 3 + k, 32'(8 + 4 * k), 32'(4 * k));
            end
        end
    endtask

    task automatic test_req_stall();
        imem_req_ready = 1'b0;
        ins_ready      = 1'b1;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || ins_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_%0d got v=%b a=%h iv=%b want 1/0/0", i, imem_req_valid, imem_req_addr, ins_valid);
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        wait_deliv(1);
        n_tests++;
        if (log_at(del_pc, 0) !== 32'h0) begin n_fail++; $display("FAIL stall_resume got %h want 00000000", log_at(del_pc, 0)); end
    endtask

    task automatic test_redirect_drain();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        do_reset();
        mem_hold = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (acc_log.size() != 2 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_outstanding got n=%0d rv=%b want 2/0", acc_log.size(), imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b0 || ins_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_drain got rv=%b iv=%b want 0/0", imem_req_valid, ins_valid);
        end
        clear_logs();
        mem_hold = 1'b0;
        wait_deliv(2);
        n_tests++;
        if (log_at(acc_log, 0) !== 32'h100 || log_at(del_pc, 0) !== 32'h100 ||
            log_at(del_ins, 0) !== mem_word(32'h100) || log_at(del_pc, 1) !== 32'h104) begin
            n_fail++; $display("FAIL rd_target got addr=%h pc0=%h ins0=%h pc1=%h want 100/100/%h/104",
                log_at(acc_log, 0), log_at(del_pc, 0), log_at(del_ins, 0), log_at(del_pc, 1), mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_with_rsp();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        do_reset();
        mem_hold = 1'b1;
        repeat (5) @(negedge clk);
        mem_hold = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++;
        if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL rr_flush got iv=%b want 0", ins_valid); end
        clear_logs();
        wait_deliv(1);
        n_tests++;
        if (log_at(acc_log, 0) !== 32'h200 || log_at(del_pc, 0) !== 32'h200 || log_at(del_ins, 0) !== mem_word(32'h200)) begin
            n_fail++; $display("FAIL rr_drop_count got addr=%h pc=%h ins=%h want 200/200/%h",
                log_at(acc_log, 0), log_at(del_pc, 0), log_at(del_ins, 0), mem_word(32'h200));
        end
    endtask

    task automatic test_reset_midstream();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        n_tests++;
        if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got iv=%b want 1", ins_valid); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (ins_valid !== 1'b0 || ins !== 32'h0000_0013 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got iv=%b ins=%h rv=%b want 0/00000013/0", ins_valid, ins, imem_req_valid);
        end
        @(negedge clk);
        @(negedge clk);
        clear_logs();
        ins_ready = 1'b1;
        rst       = 1'b1;
        wait_deliv(1);
        n_tests++;
        if (log_at(acc_log, 0) !== 32'h0 || log_at(del_pc, 0) !== 32'h0) begin
            n_fail++; $display("FAIL mid_restart got addr=%h pc=%h want 0/0", log_at(acc_log, 0), log_at(del_pc, 0));
        end
    endtask

    task automatic test_wrap();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        clear_logs();
        wait_deliv(2);
        n_tests++;
        if (log_at(acc_log, 0) !== 32'hFFFF_FFFC || log_at(acc_log, 1) !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr got %h,%h want fffffffc,00000000", log_at(acc_log, 0), log_at(acc_log, 1));
        end
        n_tests++;
        if (log_at(del_pc, 0) !== 32'hFFFF_FFFC || log_at(del_pc, 1) !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc got %h,%h want fffffffc,00000000", log_at(del_pc, 0), log_at(del_pc, 1));
        end
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        ins_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_hold       = 1'b0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_drain();
        test_redirect_with_rsp();
        test_reset_midstream();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
